// File: rtl/namuru_pkg.sv
// Shared definitions for the dump scheduler: record layout constants,
// serialiser state encoding and the header word builder.
package namuru_pkg;

  localparam logic [7:0] HDR_TAG   = 8'hD0;
  localparam int         REC_WORDS = 4;
  localparam int         ACC_W     = 16;
  localparam int         DUMP_W    = 6 * ACC_W;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_W0   = 3'd2,
    ST_W1   = 3'd3,
    ST_W2   = 3'd4
  } ser_state_t;

  function automatic logic [31:0] hdr_word(input logic [3:0] ch, input logic [15:0] cnt);
    return {HDR_TAG, 4'h0, ch, cnt};
  endfunction

endpackage

// File: rtl/namuru_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy output.
// Ports:
//   clk, rst      clock and synchronous active-high clear
//   wr, din       push one word (dropped when full)
//   rd            pop the head word (ignored when empty)
//   dout          head word, forced to 0 while empty
//   empty, level  status; level counts 0..2**AW words
module namuru_sync_fifo #(
  parameter int W  = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [W-1:0]  din,
  input  logic          rd,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_level;
  logic          w_do_wr;
  logic          w_do_rd;

  // Level reaches exactly 2**AW when full, so its top bit alone flags full.
  assign w_do_wr = wr && !r_level[AW];
  assign w_do_rd = rd && (r_level != '0);

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wp] <= din;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_do_wr) r_wp <= r_wp + 1'b1;
      if (w_do_rd) r_rp <= r_rp + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign empty = (r_level == '0);
  assign dout  = empty ? '0 : r_mem[r_rp];
  assign level = r_level;

endmodule

// File: rtl/namuru_dump_scheduler.sv
// Collects accumulation dumps from NCH tracking channels and serialises each
// one into a shared word FIFO as a 4-word record (header + 3 data words).
// Ports:
//   correlator_clk/rst  clock, synchronous active-high reset
//   flush               software reset pulse, same effect as reset
//   ch_dump, ch_acc     per-channel dump strobe and 96-bit accumulator bundle
//   fifo_rd/dout/empty/level  firmware read side of the record FIFO
//   ovr_clr, overrun    sticky per-channel overrun flags and their clear
//   rec_ready           at least one complete record is readable
module namuru_dump_scheduler
  import namuru_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int FIFO_AW = 6
) (
  input  logic                  correlator_clk,
  input  logic                  correlator_rst,
  input  logic                  flush,
  input  logic [NCH-1:0]        ch_dump,
  input  logic [NCH*DUMP_W-1:0] ch_acc,
  input  logic                  fifo_rd,
  output logic [31:0]           fifo_dout,
  output logic                  fifo_empty,
  output logic [FIFO_AW:0]      fifo_level,
  input  logic [NCH-1:0]        ovr_clr,
  output logic [NCH-1:0]        overrun,
  output logic                  rec_ready
);

  localparam int IW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] SPACE_LIMIT = (FIFO_AW+1)'(DEPTH - REC_WORDS);
  localparam logic [FIFO_AW:0] REC_LEVEL   = (FIFO_AW+1)'(REC_WORDS);

  logic              w_clr;
  logic [DUMP_W-1:0] r_hold [NCH];
  logic [NCH-1:0]    r_pend;
  logic [NCH-1:0]    r_ovr;
  logic [IW-1:0]     r_rr;
  ser_state_t        r_state;
  ser_state_t        w_state_nxt;
  logic [DUMP_W-1:0] r_ser;
  logic [IW-1:0]     r_gch;
  logic [15:0]       r_rec_cnt;
  logic              w_found;
  logic [IW-1:0]     w_gidx;
  logic              w_grant;
  logic [NCH-1:0]    w_gmask;
  logic              w_wr;
  logic [31:0]       w_wdata;

  assign w_clr = correlator_rst | flush;

  // Round-robin pick: the lowest pending channel above r_rr wins; if none,
  // wrap around to the lowest pending channel at or below r_rr.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (r_pend[k] && (k <= int'(r_rr))) begin
        w_found = 1'b1;
        w_gidx  = IW'(k);
      end
    end
    for (int k = NCH - 1; k >= 0; k--) begin
      if (r_pend[k] && (k > int'(r_rr))) begin
        w_found = 1'b1;
        w_gidx  = IW'(k);
      end
    end
  end

  // A record is only started when all four words fit, so the serialiser never stalls.
  assign w_grant = (r_state == ST_IDLE) && w_found && (fifo_level <= SPACE_LIMIT);
  assign w_gmask = w_grant ? (NCH'(1) << w_gidx) : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_wdata     = '0;
    unique case (r_state)
      ST_IDLE: if (w_grant) w_state_nxt = ST_HDR;
      ST_HDR: begin
        w_wr        = 1'b1;
        w_wdata     = hdr_word(4'(r_gch), r_rec_cnt);
        w_state_nxt = ST_W0;
      end
      ST_W0: begin
        w_wr        = 1'b1;
        w_wdata     = r_ser[95:64];
        w_state_nxt = ST_W1;
      end
      ST_W1: begin
        w_wr        = 1'b1;
        w_wdata     = r_ser[63:32];
        w_state_nxt = ST_W2;
      end
      ST_W2: begin
        w_wr        = 1'b1;
        w_wdata     = r_ser[31:0];
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A dump on the channel being granted re-arms pend with fresh data and is
  // not an overrun; overrun set takes priority over a same-cycle clear.
  always_ff @(posedge correlator_clk) begin
    if (w_clr) begin
      r_state   <= ST_IDLE;
      r_pend    <= '0;
      r_ovr     <= '0;
      r_rr      <= '0;
      r_rec_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= (r_pend & ~w_gmask) | ch_dump;
      r_ovr   <= (r_ovr & ~ovr_clr) | (ch_dump & r_pend & ~w_gmask);
      if (w_grant) r_rr <= w_gidx;
      if (r_state == ST_W2) r_rec_cnt <= r_rec_cnt + 16'd1;
    end
  end

  always_ff @(posedge correlator_clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (w_clr)           r_hold[k] <= '0;
      else if (ch_dump[k]) r_hold[k] <= ch_acc[k*DUMP_W +: DUMP_W];
    end
    if (w_grant) begin
      r_ser <= r_hold[w_gidx];
      r_gch <= w_gidx;
    end
  end

  namuru_sync_fifo #(
    .W  (32),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (correlator_clk),
    .rst   (w_clr),
    .wr    (w_wr),
    .din   (w_wdata),
    .rd    (fifo_rd),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign overrun   = r_ovr;
  assign rec_ready = (fifo_level >= REC_LEVEL) || ((fifo_level != '0) && (r_state == ST_IDLE));

endmodule
